// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO, with single-cycle MTHI/MTLO.
// Results are computed when the op is accepted and held pending until the busy window expires.
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0] hi_d, lo_d, pend_hi, pend_lo;
    logic        pend_we;
    logic        is_arith, is_div, accept;
    logic [63:0] smul, umul, res;
    logic [31:0] ua, ub, uq, ur, sa, sb, sq_mag, sr_mag, sq, sr;

    assign is_arith = (md_op >= 3'd1) && (md_op <= 3'd4);
    assign is_div = (md_op == 3'd3) || (md_op == 3'd4);
    assign accept = (state == IDLE) && start && is_arith;
    assign busy = (state == RUN);
    assign stall_req = busy | (start && (md_op >= 3'd1) && (md_op <= 3'd6));

    assign smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign umul = {32'b0, A} * {32'b0, B};
    assign ua = A;
    assign ub = B;
    assign uq = ua / ub;
    assign ur = ua % ub;
    // Signed divide through magnitudes keeps INT_MIN / -1 well defined (wraps to INT_MIN).
    assign sa = A[31] ? -A : A;
    assign sb = B[31] ? -B : B;
    assign sq_mag = sa / sb;
    assign sr_mag = sa % sb;
    assign sq = (A[31] ^ B[31]) ? -sq_mag : sq_mag;
    assign sr = A[31] ? -sr_mag : sr_mag;
    assign res = (md_op == 3'd1) ? smul :
                 (md_op == 3'd2) ? umul :
                 (md_op == 3'd3) ? {sr, sq} : {ur, uq};

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        hi_d = hi;
        lo_d = lo;
        if (state == RUN) begin
            cnt_d = cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state_d = IDLE;
                hi_d = pend_we ? pend_hi : hi;
                lo_d = pend_we ? pend_lo : lo;
            end
        end else if (start) begin
            if (is_arith) begin
                state_d = RUN;
                cnt_d = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end
            hi_d = (md_op == 3'd5) ? A : hi;
            lo_d = (md_op == 3'd6) ? A : lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            hi <= hi_d;
            lo <= lo_d;
            if (accept) begin
                pend_hi <= res[63:32];
                pend_lo <= res[31:0];
                pend_we <= !(is_div && B == 32'd0);
            end
        end
    end
endmodule
